seg7_capture: RTL and testbench

Sampling decoder for multiplexed 7-segment display buses: the receive side of our hex-to-segment encoders. It synchronises the external segment and anode lines, waits for each pattern to be stable, decodes the lit pattern back to a 4-bit hex value, and holds one register per digit position. It sits on a test/loopback board input and lets another FPGA's display output be read back as data.

---
 rtl/seg7_pkg.sv | 87 ++++++++
 rtl/seg7_decode.sv | 18 +
 rtl/seg7_capture.sv | 138 +++++++++++++
 tb/tb_seg7_capture.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions used by the hex encoders and by the capture decoder.
// All glyph constants are active-high, bit 0 = a ... bit 6 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic       hit;
    logic [3:0] code;
  } seg7_match_t;

  // What a stable sample turns into, decided by how many anodes are lit.
  typedef enum logic [1:0] {
    CMT_NONE,
    CMT_WRITE,
    CMT_MULTI
  } commit_kind_t;

  function automatic logic [6:0] seg7_encode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

  // Inverse of seg7_encode; hit is low for anything outside the glyph table.
  function automatic seg7_match_t seg7_match(input logic [6:0] pat);
    seg7_match_t m;
    m.hit = 1'b1;
    case (pat)
      SEG_0: m.code = 4'h0;
      SEG_1: m.code = 4'h1;
      SEG_2: m.code = 4'h2;
      SEG_3: m.code = 4'h3;
      SEG_4: m.code = 4'h4;
      SEG_5: m.code = 4'h5;
      SEG_6: m.code = 4'h6;
      SEG_7: m.code = 4'h7;
      SEG_8: m.code = 4'h8;
      SEG_9: m.code = 4'h9;
      SEG_A: m.code = 4'hA;
      SEG_B: m.code = 4'hB;
      SEG_C: m.code = 4'hC;
      SEG_D: m.code = 4'hD;
      SEG_E: m.code = 4'hE;
      SEG_F: m.code = 4'hF;
      default: begin
        m.hit  = 1'b0;
        m.code = 4'h0;
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern decoder: active-high pattern in, {hit, blank, hex} out.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic       hit,
  output logic       blank,
  output logic [3:0] hex
);

  seg7_match_t m;

  assign m     = seg7_match(pat);
  assign hit   = m.hit;
  assign hex   = m.code;
  assign blank = (pat == SEG_BLANK);

endmodule

// File: rtl/seg7_capture.sv
// Reads a multiplexed 7-segment bus back into per-digit hex registers, committing
// a pattern only after it has been stable for STABLE synchronised samples.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter bit INVERT    = 1'b1,
  parameter bit AN_INVERT = 1'b1,
  parameter int DIGITS    = 4,
  parameter int STABLE    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   hex,
  output logic [DIGITS-1:0]     valid,
  output logic [DIGITS-1:0]     blank,
  output logic                  update,
  output logic                  err
);

  localparam logic [6:0]        SEG_IDLE  = INVERT ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_IDLE   = AN_INVERT ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        STABLE_C  = 8'(STABLE);
  localparam logic [7:0]        STABLE_M1 = 8'(STABLE - 1);

  logic [6:0]          seg_s1, seg_s2;
  logic [DIGITS-1:0]   an_s1, an_s2;
  logic [7:0]          cnt;
  logic                same;
  logic                commit;
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic [3:0]          n_an;
  commit_kind_t        kind;
  logic                dec_hit, dec_blank;
  logic [3:0]          dec_hex;
  logic [4*DIGITS-1:0] hex_nx;
  logic [DIGITS-1:0]   valid_nx, blank_nx;
  logic                update_nx, err_nx;

  // Idle level is the inactive pin level so a freshly reset bus reads as all off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1 <= SEG_IDLE;
      seg_s2 <= SEG_IDLE;
      an_s1  <= AN_IDLE;
      an_s2  <= AN_IDLE;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      an_s1  <= an;
      an_s2  <= an_s1;
    end
  end

  // The sample entering stage 2 is compared with the one already there.
  assign same   = (seg_s1 == seg_s2) && (an_s1 == an_s2);
  assign commit = same && (cnt == STABLE_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (!same) begin
      cnt <= 8'd0;
    end else if (cnt != STABLE_C) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign seg_n = seg_s2 ^ {7{INVERT}};
  assign an_n  = an_s2 ^ {DIGITS{AN_INVERT}};

  always_comb begin
    n_an = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_n[i]) n_an = n_an + 4'd1;
    end
    if (n_an == 4'd0)      kind = CMT_NONE;
    else if (n_an == 4'd1) kind = CMT_WRITE;
    else                   kind = CMT_MULTI;
  end

  seg7_decode u_decode (
    .pat   (seg_n),
    .hit   (dec_hit),
    .blank (dec_blank),
    .hex   (dec_hex)
  );

  // Unrecognised and blank patterns keep the old hex nibble; only the flags move.
  always_comb begin
    hex_nx    = hex;
    valid_nx  = valid;
    blank_nx  = blank;
    update_nx = 1'b0;
    err_nx    = 1'b0;
    if (commit) begin
      case (kind)
        CMT_MULTI: err_nx = 1'b1;
        CMT_WRITE: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (an_n[i]) begin
              if (dec_hit) begin
                hex_nx[4*i +: 4] = dec_hex;
                valid_nx[i]      = 1'b1;
                blank_nx[i]      = 1'b0;
              end else begin
                valid_nx[i] = 1'b0;
                blank_nx[i] = dec_blank;
              end
            end
          end
          err_nx    = !dec_hit && !dec_blank;
          update_nx = ({hex_nx, valid_nx, blank_nx} != {hex, valid, blank});
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex    <= '0;
      valid  <= '0;
      blank  <= '0;
      update <= 1'b0;
      err    <= 1'b0;
    end else begin
      hex    <= hex_nx;
      valid  <= valid_nx;
      blank  <= blank_nx;
      update <= update_nx;
      err    <= err_nx;
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with active-low segments and anodes, four digits,
// and a stability window of four samples.
module tb_seg7_capture;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] hex;
  logic [3:0]  valid;
  logic [3:0]  blank;
  logic        update;
  logic        err;

  int compared   = 0;
  int mismatched = 0;
  int upd_cnt    = 0;
  int err_cnt    = 0;

  seg7_capture #(
    .INVERT    (1'b1),
    .AN_INVERT (1'b1),
    .DIGITS    (4),
    .STABLE    (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seg    (seg),
    .an     (an),
    .hex    (hex),
    .valid  (valid),
    .blank  (blank),
    .update (update),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses are one clock wide, so every pulse is seen at exactly one falling edge.
  always @(negedge clk) begin
    if (update) upd_cnt = upd_cnt + 1;
    if (err)    err_cnt = err_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared = compared + 1;
    if (got !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // pat is active-high; pins are driven inverted. Returns 1ns after the
  // (cycles)-th rising edge counted from the first edge that sees the new pins.
  task automatic applyStimulus(input logic [6:0] pat, input logic [3:0] an_pins, input int cycles);
    @(negedge clk);
    seg = ~pat;
    an  = an_pins;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic clearCounts();
    upd_cnt = 0;
    err_cnt = 0;
  endtask

  initial begin
    seg = 7'h7F;
    an  = 4'hF;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hex",    32'(hex),    32'h0);
    checkOutput("reset_valid",  32'(valid),  32'h0);
    checkOutput("reset_blank",  32'(blank),  32'h0);
    checkOutput("reset_update", 32'(update), 32'h0);
    checkOutput("reset_err",    32'(err),    32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Digit 1 shows "2": commit lands on edge k+5
    clearCounts();
    applyStimulus(7'h5B, 4'b1101, 5);
    checkOutput("t1_before_commit_valid", 32'(valid[1]), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("t1_hex1",   32'(hex[7:4]), 32'h2);
    checkOutput("t1_valid1", 32'(valid[1]), 32'h1);
    checkOutput("t1_blank1", 32'(blank[1]), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t1_updates", 32'(upd_cnt), 32'd1);
    checkOutput("t1_errs",    32'(err_cnt), 32'd0);

    // Three-sample glitch to "1" inside the "2" run
    clearCounts();
    applyStimulus(7'h06, 4'b1101, 3);
    applyStimulus(7'h5B, 4'b1101, 10);
    checkOutput("t2_updates", 32'(upd_cnt),  32'd0);
    checkOutput("t2_errs",    32'(err_cnt),  32'd0);
    checkOutput("t2_hex1",    32'(hex[7:4]), 32'h2);
    checkOutput("t2_valid1",  32'(valid[1]), 32'h1);

    // All sixteen glyphs on digit 0
    clearCounts();
    for (int c = 0; c < 16; c++) begin
      applyStimulus(SEG_TAB[c], 4'b1110, 8);
      checkOutput($sformatf("t3_hex0_%0d", c), 32'(hex[3:0]), 32'(c));
      checkOutput($sformatf("t3_valid0_%0d", c), 32'(valid[0]), 32'h1);
    end
    checkOutput("t3_updates", 32'(upd_cnt), 32'd16);
    checkOutput("t3_errs",    32'(err_cnt), 32'd0);

    // Two anodes active at once
    clearCounts();
    applyStimulus(7'h6D, 4'b1001, 10);
    checkOutput("t4_errs",    32'(err_cnt), 32'd1);
    checkOutput("t4_updates", 32'(upd_cnt), 32'd0);
    checkOutput("t4_hex",     32'(hex),     32'h002F);
    checkOutput("t4_valid",   32'(valid),   32'h3);
    checkOutput("t4_blank",   32'(blank),   32'h0);

    // Digit 3: "7", then blank, then unrecognised 0x55
    clearCounts();
    applyStimulus(7'h07, 4'b0111, 10);
    checkOutput("t5_hex3_7",    32'(hex[15:12]), 32'h7);
    checkOutput("t5_valid3_7",  32'(valid[3]),   32'h1);
    checkOutput("t5_updates_7", 32'(upd_cnt),    32'd1);
    clearCounts();
    applyStimulus(7'h00, 4'b0111, 10);
    checkOutput("t5_blank3_bl",   32'(blank[3]),   32'h1);
    checkOutput("t5_valid3_bl",   32'(valid[3]),   32'h0);
    checkOutput("t5_hex3_bl",     32'(hex[15:12]), 32'h7);
    checkOutput("t5_updates_bl",  32'(upd_cnt),    32'd1);
    checkOutput("t5_errs_bl",     32'(err_cnt),    32'd0);
    clearCounts();
    applyStimulus(7'h55, 4'b0111, 10);
    checkOutput("t5_errs_55",    32'(err_cnt),    32'd1);
    checkOutput("t5_updates_55", 32'(upd_cnt),    32'd1);
    checkOutput("t5_valid3_55",  32'(valid[3]),   32'h0);
    checkOutput("t5_blank3_55",  32'(blank[3]),   32'h0);
    checkOutput("t5_hex3_55",    32'(hex[15:12]), 32'h7);

    // Reset one edge before the commit of "9" on digit 2
    applyStimulus(7'h6F, 4'b1011, 5);
    rst = 1'b1;
    #1;
    checkOutput("t6_async_hex",   32'(hex),   32'h0);
    checkOutput("t6_async_valid", 32'(valid), 32'h0);
    checkOutput("t6_async_blank", 32'(blank), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    clearCounts();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t6_no_early_valid",  32'(valid[2]), 32'h0);
    checkOutput("t6_no_early_update", 32'(upd_cnt),  32'd0);
    @(posedge clk);
    #1;
    checkOutput("t6_valid2",  32'(valid[2]),   32'h1);
    checkOutput("t6_hex2",    32'(hex[11:8]),  32'h9);
    checkOutput("t6_update",  32'(update),     32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
